// File: rtl/ac1_bitplane_feed.sv
// ac1_bitplane_feed: bit-serial front end of the accumulator datapath.
// Each accepted beat carries one activation bit-plane and one weight bit-plane
// over M lanes, LSB-first, Pa beats per word. The block computes
// popcount(act & wgt) and drives the downstream shift register with the data
// and its write-and-shift / clear controls.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid, in_ready  beat handshake (in_ready = rst_n & !abort)
//   act_bits, wgt_bits  M-lane activation / weight bit-planes
//   abort               drop the partial word and clear downstream
//   pc_out              popcount to the shift-register data input
//   w_and_s, cl_en      shift-register write-and-shift and clear strobes
//   bit_idx             index of the next beat to be accepted
//   word_done           pulse: downstream register holds the finished word
//
// Configuration macro: AC1_POPCNT_PIPE_EN splits the popcount into two register
// stages (half sums, then add); every output latency grows by one cycle.
module ac1_bitplane_feed #(
   parameter int unsigned M  = 16,
   parameter int unsigned Pa = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [M-1:0]            act_bits,
   input  logic [M-1:0]            wgt_bits,
   input  logic                    abort,
   output logic [$clog2(M):0]      pc_out,
   output logic                    w_and_s,
   output logic                    cl_en,
   output logic [$clog2(Pa)-1:0]   bit_idx,
   output logic                    word_done
);

   localparam int unsigned PW = $clog2(M) + 1;
   localparam int unsigned IW = $clog2(Pa);
   localparam int unsigned H  = M / 2;

   logic          accept;
   logic [M-1:0]  prod;
   logic [PW-1:0] sum_lo;
   logic [PW-1:0] sum_hi;
   logic          is_first;
   logic          is_last;

   logic [IW-1:0] bit_idx_q, bit_idx_d;
   logic [PW-1:0] pc_q, pc_d;
   logic          ws_q, ws_d;
   logic          cl_q, cl_d;
   logic          last_q, last_d;
   logic          done_q, done_d;

   assign in_ready = rst_n & ~abort;
   assign accept   = in_valid & in_ready;
   assign prod     = act_bits & wgt_bits;
   assign is_first = (bit_idx_q == '0);
   assign is_last  = (bit_idx_q == IW'(Pa - 1));

   // Two half sums; each is PW bits wide so the full count M never wraps.
   always_comb begin
      sum_lo = '0;
      sum_hi = '0;
      for (int unsigned i = 0; i < M; i++) begin
         if (i < H) sum_lo = sum_lo + PW'(prod[i]);
         else       sum_hi = sum_hi + PW'(prod[i]);
      end
   end

   always_comb begin
      bit_idx_d = bit_idx_q;
      if (abort)       bit_idx_d = '0;
      else if (accept) bit_idx_d = is_last ? '0 : bit_idx_q + IW'(1);
   end

`ifdef AC1_POPCNT_PIPE_EN
   // Stage A: half sums plus the control flags of the beat they belong to.
   logic [PW-1:0] a_lo_q, a_lo_d;
   logic [PW-1:0] a_hi_q, a_hi_d;
   logic          a_vld_q, a_vld_d;
   logic          a_first_q, a_first_d;
   logic          a_last_q, a_last_d;
   logic          a_clr_q, a_clr_d;

   always_comb begin
      a_lo_d    = accept ? sum_lo : a_lo_q;
      a_hi_d    = accept ? sum_hi : a_hi_q;
      a_vld_d   = accept;
      a_first_d = accept & is_first;
      a_last_d  = accept & is_last;
      a_clr_d   = abort;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_lo_q    <= '0;
         a_hi_q    <= '0;
         a_vld_q   <= 1'b0;
         a_first_q <= 1'b0;
         a_last_q  <= 1'b0;
         a_clr_q   <= 1'b0;
      end else begin
         a_lo_q    <= a_lo_d;
         a_hi_q    <= a_hi_d;
         a_vld_q   <= a_vld_d;
         a_first_q <= a_first_d;
         a_last_q  <= a_last_d;
         a_clr_q   <= a_clr_d;
      end
   end

   // Output stage: an abort in flight squashes the beat in stage A so the
   // clear strobe arrives alone, one cycle later.
   always_comb begin
      ws_d   = a_vld_q & ~abort;
      cl_d   = (a_vld_q & a_first_q & ~abort) | a_clr_q;
      last_d = a_last_q & ~abort;
      pc_d   = (a_vld_q & ~abort) ? a_lo_q + a_hi_q : pc_q;
   end
`else
   always_comb begin
      ws_d   = accept;
      cl_d   = (accept & is_first) | abort;
      last_d = accept & is_last;
      pc_d   = accept ? sum_lo + sum_hi : pc_q;
   end
`endif

   // The last strobe lands in the shift register at the end of its cycle, so
   // the word is complete one cycle later unless an abort intervenes.
   assign done_d = last_q & ~abort;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_idx_q <= '0;
         pc_q      <= '0;
         ws_q      <= 1'b0;
         cl_q      <= 1'b0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         bit_idx_q <= bit_idx_d;
         pc_q      <= pc_d;
         ws_q      <= ws_d;
         cl_q      <= cl_d;
         last_q    <= last_d;
         done_q    <= done_d;
      end
   end

   assign pc_out    = pc_q;
   assign w_and_s   = ws_q;
   assign cl_en     = cl_q;
   assign bit_idx   = bit_idx_q;
   assign word_done = done_q;

endmodule

// File: tb/tb_ac1_bitplane_feed.sv
// Bench for ac1_bitplane_feed: directed and randomized beats checked against a
// schedule of expected output events derived from the beat-level rules, plus a
// consumer shift-register model whose final word is compared at word_done.
module tb_ac1_bitplane_feed;

   localparam int M  = 16;
   localparam int PA = 8;
`ifdef AC1_POPCNT_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [M-1:0]  act_bits;
   logic [M-1:0]  wgt_bits;
   logic          abort;
   logic [4:0]    pc_out;
   logic          w_and_s;
   logic          cl_en;
   logic [2:0]    bit_idx;
   logic          word_done;

   ac1_bitplane_feed #(.M(M), .Pa(PA)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .act_bits  (act_bits),
      .wgt_bits  (wgt_bits),
      .abort     (abort),
      .pc_out    (pc_out),
      .w_and_s   (w_and_s),
      .cl_en     (cl_en),
      .bit_idx   (bit_idx),
      .word_done (word_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Expected events indexed by cycle.
   bit ew   [0:2047];
   bit ecl  [0:2047];
   bit ed   [0:2047];
   bit erst [0:2047];
   int epc  [0:2047];
   int edv  [0:2047];

   int cur_pc = 0;
   int m_idx  = 0;
   int m_word = 0;
   int ds_acc = 0;
   int ds_n   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit v, input logic [M-1:0] a, input logic [M-1:0] w,
                       input bit ab, input bit rn);
      int pc;
      in_valid = v;
      act_bits = a;
      wgt_bits = w;
      abort    = ab;
      rst_n    = rn;
      #1;
      if (erst[cyc]) cur_pc = 0;
      if (ew[cyc])   cur_pc = epc[cyc];
      chk("in_ready", 32'(in_ready), 32'(rn & ~ab));
      chk("w_and_s", 32'(w_and_s), 32'(ew[cyc]));
      chk("cl_en", 32'(cl_en), 32'(ecl[cyc]));
      chk("pc_out", 32'(pc_out), cur_pc);
      chk("bit_idx", 32'(bit_idx), m_idx);
      chk("word_done", 32'(word_done), 32'(ed[cyc]));
      if (ed[cyc]) chk("word_value", ds_acc, edv[cyc]);
      // Consumer shift register updates at the end of this cycle.
      if (w_and_s && cl_en) begin
         ds_acc = int'(pc_out);
         ds_n   = 1;
      end else if (w_and_s) begin
         ds_acc = ds_acc + (int'(pc_out) << ds_n);
         ds_n++;
      end else if (cl_en) begin
         ds_acc = 0;
         ds_n   = 0;
      end
      // Reference model of the beat rules.
      if (!rn || ab) begin
         for (int i = cyc + 1; i <= cyc + 4; i++) begin
            ew[i]  = 1'b0;
            ecl[i] = 1'b0;
            ed[i]  = 1'b0;
         end
         m_idx = 0;
      end
      if (!rn) erst[cyc+1] = 1'b1;
      else if (ab) ecl[cyc+LAT] = 1'b1;
      if (v && rn && !ab) begin
         pc = $countones(a & w);
         ew[cyc+LAT]  = 1'b1;
         ecl[cyc+LAT] = (m_idx == 0);
         epc[cyc+LAT] = pc;
         if (m_idx == 0) m_word = pc;
         else            m_word = m_word + (pc << m_idx);
         if (m_idx == PA - 1) begin
            ed[cyc+LAT+1]  = 1'b1;
            edv[cyc+LAT+1] = m_word;
         end
         m_idx = (m_idx + 1) % PA;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic beat(input logic [M-1:0] a, input logic [M-1:0] w);
      step(1'b1, a, w, 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
   endtask

   task automatic word(input logic [M-1:0] a, input logic [M-1:0] w);
      for (int i = 0; i < PA; i++) beat(a, w);
   endtask

   initial begin
      int k;
      logic [M-1:0] ra;
      logic [M-1:0] rw;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      abort    = 1'b0;
      act_bits = '0;
      wgt_bits = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, then the 4 x 255 = 1020 word.
      chk("reset_word_done", 32'(word_done), 32'd0);
      word(16'h000F, 16'hFFFF);
      idle(3);

      // Full-count no-wrap word, then zero-weight word, back to back.
      word(16'hFFFF, 16'hFFFF);
      word(16'hFFFF, 16'h0000);
      idle(3);

      // Random words with bubbles.
      for (int n = 0; n < 5; n++) begin
         k = 0;
         while (k < PA) begin
            if ($urandom_range(0, 2) != 0) begin
               ra = 16'($urandom);
               rw = 16'($urandom);
               beat(ra, rw);
               k++;
            end else begin
               idle(1);
            end
         end
      end
      idle(3);

      // Random back-to-back words.
      for (int n = 0; n < 3 * PA; n++) beat(16'($urandom), 16'($urandom));
      idle(3);

      // Abort after three beats, valid held high during the abort.
      for (int i = 0; i < 3; i++) beat(16'h00FF, 16'h0F0F);
      step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      idle(2);
      word(16'h1234, 16'hFFFF);
      idle(3);

      // Abort right after the last beat: its word_done must be squashed.
      word(16'hAAAA, 16'hFFFF);
      step(1'b0, '0, '0, 1'b1, 1'b1);
      idle(4);

      // One-cycle reset mid-word, then a full word.
      for (int i = 0; i < 4; i++) beat(16'hF0F0, 16'hFFFF);
      step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      idle(1);
      word(16'h0FF0, 16'h3C3C);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ac1_bitplane_feed.md
# ac1_bitplane_feed

Bit-serial front end of the accumulator datapath. It accepts one activation bit-plane and one weight bit-plane per beat over M lanes, LSB-first, Pa beats per operand word. For each beat it computes the popcount of (act AND wgt) across the M lanes and drives the downstream accumulator shift register with data and its `w_and_s`/`cl_en` controls. It signals when that register holds a complete Pa-bit-weighted result.

## Interface
- `M`, default 16: lane count, i.e. the number of bit products summed per beat.
- `Pa`, default 8: activation operand parallelism, i.e. beats per word (Pa ≥ 2).
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst_n`  in  1: synchronous reset, active-low.
- `in_valid`  in  1: a bit-plane beat is presented.
- `in_ready`  out  1: the beat is accepted when `in_valid & in_ready`.
- `act_bits`  in  M: activation bit-plane for the current bit position.
- `wgt_bits`  in  M: weight bits, one per lane.
- `abort`  in  1: discard the partial word and clear downstream.
- `pc_out`  out  $clog2(M)+1: popcount feeding the shift-register data input.
- `w_and_s`  out  1: write-and-shift strobe to the shift register.
- `cl_en`  out  1: clear enable to the shift register.
- `bit_idx`  out  $clog2(Pa): index of the next beat to be accepted.
- `word_done`  out  1: one-cycle pulse; the downstream register holds the final word.

## Operation
- Reset (`rst_n`=0 at an edge): `pc_out`=0, `w_and_s`=0, `cl_en`=0, `bit_idx`=0, `word_done`=0, pipeline valid flags cleared. `in_ready`=0 while `rst_n`=0.
- `in_ready` = `rst_n & !abort`. It is combinational; the block has no other backpressure.
- Accepted beat: `pc` = number of set bits in `act_bits & wgt_bits`. The range is 0..M, held in $clog2(M)+1 bits; the value M is legal and must not wrap.
- Control encoding on the output stage:
  - Accepted beat with `bit_idx`==0: `w_and_s`=1, `cl_en`=1 (clean write).
  - Accepted beat with `bit_idx`>0: `w_and_s`=1, `cl_en`=0 (shift in).
  - No beat: `w_and_s`=0, `cl_en`=0, so downstream holds.
  - Abort: `w_and_s`=0, `cl_en`=1, so downstream clears.
- `bit_idx` increments on every accepted beat and wraps from Pa-1 to 0. When `bit_idx`==Pa-1 is accepted, that beat is tagged "last".
- Bubbles (`in_valid`=0) between beats of a word are legal. The counter and downstream contents hold.
- Abort has priority over `in_valid`. Abort sets `bit_idx`=0 next cycle and kills all in-flight beats, including any pending `word_done`. It emits exactly one clear strobe, and the next accepted beat is bit 0.
- `pc_out` holds its last value when `w_and_s`=0. Downstream ignores it in that case.

## Timing
- Base latency (macro off): beat accepted in cycle t, then `pc_out`/`w_and_s`/`cl_en` are registered and valid in cycle t+1. The downstream register updates at the end of t+1.
- `word_done` is high in cycle t+2 for the last beat accepted at t, which is the first cycle the downstream register holds the full word.
- Throughput is one beat per cycle, so back-to-back words have no gap. The bit 0 of word n+1 may be accepted in the cycle after bit Pa-1 of word n. `word_done` for word n and the clean write for word n+1 are then both visible in the same cycle, and the consumer samples the final value in that cycle.
- Abort asserted in cycle t: `cl_en`=1, `w_and_s`=0 in t+1 (t+2 with the macro on, with intervening strobes suppressed). `word_done` stays 0 from t+1 through the end of the flush.
- Reset mid-word: all outputs are at reset values the cycle after the reset edge. No `word_done` is produced for the partial word.

## Configuration
- `AC1_POPCNT_PIPE_EN` defined: the popcount tree is split into two register stages, with lanes summed in two halves and then added. All latencies increase by 1: outputs at t+2, `word_done` at t+3. The control flags travel with the data so strobe-to-data alignment is unchanged.
- Undefined: single-stage combinational popcount with latencies as listed in Timing.

## Test plan
- M=16, Pa=8, `wgt_bits`=16'hFFFF, 8 back-to-back beats with `act_bits`=16'h000F. Expect `pc_out`=4 each beat, `cl_en`=1 only on the first strobe, `word_done` at t+2 after the last beat, downstream value 4×255=1020.
- `act_bits`=`wgt_bits`=16'hFFFF. Expect `pc_out`=16 with no wrap. `act_bits`=16'hFFFF with `wgt_bits`=0. Expect `pc_out`=0.
- Random bubbles inserted within a word. `word_done` occurs exactly once, after the 8th accepted beat, and the result equals the gap-free run.
- Abort after 3 beats. Expect a single `cl_en`=1/`w_and_s`=0 strobe, `bit_idx`=0, no `word_done`. The next beat is a clean write.
- `rst_n`=0 for one cycle mid-word. Expect all outputs 0 the next cycle and `in_ready`=0 during reset. A full word after reset completes correctly.
- Repeat all of the above with `AC1_POPCNT_PIPE_EN` defined and check every latency is +1.
